// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] round sequencer: loads the input state, steps the round index UNROLL rounds per clock, reports done.
// Latency: start handshake at T -> RUN on T+1..T+NUM_ROUNDS/UNROLL -> out_valid_o at T+NUM_ROUNDS/UNROLL+1.
// Backpressure: out_valid_o is held in DONE until out_ready_i; a same-cycle restart is accepted. KECCAK_ROUND_CTRL_PERF_EN adds perf counters.
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int UNROLL     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid_i,
  output logic       start_ready_o,
  output logic       load_en_o,
  output logic       round_en_o,
  output logic [4:0] round_num_o,
  output logic       last_round_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o
`ifdef KECCAK_ROUND_CTRL_PERF_EN
  ,
  output logic [31:0] perm_count_o,
  output logic [31:0] stall_count_o
`endif
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24 || UNROLL < 1 || (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_cfg
    $error("keccak_round_ctrl: NUM_ROUNDS must be 1..24 and a multiple of UNROLL");
  end

  localparam logic [4:0] LAST_CNT = 5'(NUM_ROUNDS - UNROLL);
  localparam logic [4:0] STEP     = 5'(UNROLL);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       start_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start_ready_o = 1'b0;
    load_en_o     = 1'b0;
    round_en_o    = 1'b0;
    round_num_o   = 5'd0;
    last_round_o  = 1'b0;
    out_valid_o   = 1'b0;
    busy_o        = 1'b0;
    start_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        start_hs      = start_valid_i;
        if (start_hs) begin
          load_en_o = 1'b1;
          cnt_d     = 5'd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        busy_o       = 1'b1;
        round_en_o   = 1'b1;
        round_num_o  = cnt_q;
        last_round_o = (cnt_q == LAST_CNT);
        if (last_round_o) begin
          cnt_d   = 5'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      DONE: begin
        busy_o        = 1'b1;
        out_valid_o   = 1'b1;
        start_ready_o = out_ready_i;
        start_hs      = start_valid_i & out_ready_i;
        // Retiring the result and loading the next request share this cycle.
        if (out_ready_i) begin
          cnt_d = 5'd0;
          if (start_valid_i) begin
            load_en_o = 1'b1;
            state_d   = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

`ifdef KECCAK_ROUND_CTRL_PERF_EN
  // Saturating counters; cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_count_o  <= 32'd0;
      stall_count_o <= 32'd0;
    end else if (state_q == DONE) begin
      if (out_ready_i) begin
        if (perm_count_o != 32'hFFFF_FFFF) perm_count_o <= perm_count_o + 32'd1;
      end else begin
        if (stall_count_o != 32'hFFFF_FFFF) stall_count_o <= stall_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: a default (UNROLL=1) and an UNROLL=4 instance, scoreboarded round/done timing.
module tb_keccak_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0, out_ready = 1'b1;
  logic       start_ready, load_en, round_en, last_round, out_valid, busy;
  logic [4:0] round_num;
  logic       u4_start_valid = 1'b0, u4_out_ready = 1'b1;
  logic       u4_start_ready, u4_load_en, u4_round_en, u4_last_round, u4_out_valid, u4_busy;
  logic [4:0] u4_round_num;
`ifdef KECCAK_ROUND_CTRL_PERF_EN
  logic [31:0] perm_count, stall_count, u4_perm_count, u4_stall_count;
`endif

  keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid_i(start_valid), .start_ready_o(start_ready),
    .load_en_o(load_en), .round_en_o(round_en), .round_num_o(round_num), .last_round_o(last_round),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
`ifdef KECCAK_ROUND_CTRL_PERF_EN
    , .perm_count_o(perm_count), .stall_count_o(stall_count)
`endif
  );

  keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(4)) dut_u4 (
    .clk(clk), .rst_n(rst_n), .start_valid_i(u4_start_valid), .start_ready_o(u4_start_ready),
    .load_en_o(u4_load_en), .round_en_o(u4_round_en), .round_num_o(u4_round_num), .last_round_o(u4_last_round),
    .out_valid_o(u4_out_valid), .out_ready_i(u4_out_ready), .busy_o(u4_busy)
`ifdef KECCAK_ROUND_CTRL_PERF_EN
    , .perm_count_o(u4_perm_count), .stall_count_o(u4_stall_count)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {int cyc; int rnum; bit last;} rnd_t;
  rnd_t rnd_q[2][$];
  int   done_q[2][$];
  bit   prev_ov[2];

  // Scoreboard: a load at cycle T schedules round steps on T+1..T+steps and done at T+steps+1.
  task automatic mon(input int id, input int steps, input int unroll, input logic ld, input logic ren,
                     input logic [4:0] rnum, input logic lst, input logic ov);
    rnd_t e;
    if (!rst_n) begin
      rnd_q[id].delete();
      done_q[id].delete();
      prev_ov[id] = 1'b0;
      return;
    end
    if (rnd_q[id].size() > 0 && rnd_q[id][0].cyc == cyc) begin
      e = rnd_q[id].pop_front();
      check(id == 0 ? "round_en" : "u4_round_en", 32'(ren), 32'd1);
      check(id == 0 ? "round_num" : "u4_round_num", 32'(rnum), 32'(e.rnum));
      check(id == 0 ? "last_round" : "u4_last_round", 32'(lst), 32'(e.last));
    end else begin
      check(id == 0 ? "round_en_idle" : "u4_round_en_idle", 32'(ren), 32'd0);
      check(id == 0 ? "round_num_idle" : "u4_round_num_idle", 32'(rnum), 32'd0);
    end
    if (ov && !prev_ov[id]) begin
      if (done_q[id].size() == 0) check(id == 0 ? "done_unexpected" : "u4_done_unexpected", 32'd1, 32'd0);
      else check(id == 0 ? "done_cycle" : "u4_done_cycle", 32'(cyc), 32'(done_q[id].pop_front()));
    end
    prev_ov[id] = ov;
    if (ld) begin
      for (int k = 1; k <= steps; k++) begin
        e.cyc = cyc + k; e.rnum = (k - 1) * unroll; e.last = (k == steps);
        rnd_q[id].push_back(e);
      end
      done_q[id].push_back(cyc + steps + 1);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 24, 1, load_en, round_en, round_num, last_round, out_valid);
    mon(1, 6, 4, u4_load_en, u4_round_en, u4_round_num, u4_last_round, u4_out_valid);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int id, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (id == 0 ? out_valid : u4_out_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, at, seen;
    bit found;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    tick; rst_n = 1'b1;
    @(negedge clk);
    check("rst_start_ready2", 32'(start_ready), 32'd1);
    check("rst_busy2", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_round_num", 32'(round_num), 32'd0);
    check("rst_u4_start_ready", 32'(u4_start_ready), 32'd1);

    // 2: single permutation, consumer always ready
    tick; start_valid = 1'b1; t0 = cyc;
    #3 check("single_load_en", 32'(load_en), 32'd1);
    tick; start_valid = 1'b0;
    check("single_busy", 32'(busy), 32'd1);
    check("single_start_ready", 32'(start_ready), 32'd0);
    wait_valid(0, 40, at);
    check("single_latency", 32'(at - t0), 32'd25);
    tick;
    check("single_valid_1cyc", 32'(out_valid), 32'd0);
    check("single_idle", 32'(busy), 32'd0);

    // 3: backpressure, 10 stalled DONE cycles with a pending start request
    tick; start_valid = 1'b1; out_ready = 1'b0; t0 = cyc;
    tick; start_valid = 1'b0;
    wait_valid(0, 40, at);
    check("bp_latency", 32'(at - t0), 32'd25);
    tick; start_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_round_en", 32'(round_en), 32'd0);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      check("bp_load_en", 32'(load_en), 32'd0);
    end
    tick; start_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_at_accept", 32'(out_valid), 32'd1);
`ifdef KECCAK_ROUND_CTRL_PERF_EN
    check("bp_stall_count", stall_count, 32'd10);
`endif
    tick;
    check("bp_valid_dropped", 32'(out_valid), 32'd0);
`ifdef KECCAK_ROUND_CTRL_PERF_EN
    check("bp_perm_count", perm_count, 32'd2);
`endif

    // 4: back-to-back requests, no bubble between retire and reload
    tick; start_valid = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check("b2b_load_on_done", 32'(load_en), 32'd1);
        check("b2b_start_ready", 32'(start_ready), 32'd1);
        seen++;
        if (seen == 2) break;
      end
    end
    check("b2b_results", 32'(seen), 32'd2);
    tick; start_valid = 1'b0;
    check("b2b_third_running", 32'(round_en), 32'd1);
    wait_valid(0, 40, at);
    tick;

    // 5: UNROLL=4 instance
    tick; u4_start_valid = 1'b1; t0 = cyc;
    tick; u4_start_valid = 1'b0;
    wait_valid(1, 20, at);
    check("u4_latency", 32'(at - t0), 32'd7);
    tick;
    check("u4_valid_1cyc", 32'(u4_out_valid), 32'd0);

    // 6: reset in the middle of a permutation
    tick; start_valid = 1'b1;
    tick; start_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (round_en && round_num == 5'd11) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_round11", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_round_en", 32'(round_en), 32'd0);
    check("abort_round_num", 32'(round_num), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_start_ready", 32'(start_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    tick; tick; rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check("abort_no_done", 32'(found), 32'd0);
    tick; start_valid = 1'b1; t0 = cyc;
    tick; start_valid = 1'b0;
    wait_valid(0, 40, at);
    check("abort_new_latency", 32'(at - t0), 32'd25);
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
